// File: rtl/crc_lfsr_engine.sv
// crc_lfsr_engine: bit-serial parametrised CRC generator with valid/ready beat input; optional received-CRC compare under CRC_CHECK_EN
module crc_lfsr_engine #(
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = 5'b00101,
  parameter logic [CRC_W-1:0] SEED = 5'b11111,
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [CRC_W-1:0]  o_crc_value,
  output logic              o_crc_valid,
`ifdef CRC_CHECK_EN
  input  logic [CRC_W-1:0]  i_rx_crc,
  output logic              o_crc_error,
`endif
  output logic              o_busy
);
  localparam int CNT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t state, state_nxt;
  logic [CRC_W-1:0] lfsr;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic last_q, accept, end_beat, bit_in, fb;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0] rx_q;
`endif
  assign accept = i_valid & o_ready;
  assign end_beat = cnt == CNT_W'(DATA_W - 1);
  assign bit_in = MSB_FIRST ? sr[DATA_W-1] : sr[0];
  assign fb = bit_in ^ lfsr[CRC_W-1];
  // state register; reset or disable always returns to IDLE
  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: one beat shifts for DATA_W cycles, then waits for more or reports
  always_comb begin
    state_nxt = state;
    if (!i_enable) state_nxt = IDLE;
    else
      case (state)
        IDLE:    state_nxt = accept ? SHIFT : IDLE;
        SHIFT:   state_nxt = end_beat ? (last_q ? DONE : GAP) : SHIFT;
        GAP:     state_nxt = accept ? SHIFT : GAP;
        default: state_nxt = IDLE;
      endcase
  end
  // handshake and status outputs; ready is forced low while reset is held
  always_comb begin
    o_ready = i_sys_rst & i_enable & (state == IDLE || state == GAP);
    o_busy = state == SHIFT || state == GAP;
  end
  // datapath: beat capture, LFSR stepping and result registers
  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) begin
      lfsr <= SEED;
      sr <= '0;
      cnt <= '0;
      last_q <= 1'b0;
      o_crc_value <= '0;
      o_crc_valid <= 1'b0;
`ifdef CRC_CHECK_EN
      rx_q <= '0;
      o_crc_error <= 1'b0;
`endif
    end else if (!i_enable) begin
      lfsr <= SEED;
      cnt <= '0;
      last_q <= 1'b0;
      o_crc_value <= '0;
      o_crc_valid <= 1'b0;
`ifdef CRC_CHECK_EN
      o_crc_error <= 1'b0;
`endif
    end else begin
      o_crc_valid <= 1'b0;
      if (accept) begin
        sr <= i_data;
        last_q <= i_last;
        if (state == IDLE) lfsr <= SEED;
`ifdef CRC_CHECK_EN
        if (i_last) rx_q <= i_rx_crc;
`endif
      end
      if (state == SHIFT) begin
        lfsr <= (lfsr << 1) ^ (fb ? POLY : '0);
        sr <= MSB_FIRST ? sr << 1 : sr >> 1;
        cnt <= end_beat ? '0 : cnt + 1'b1;
      end
      if (state == DONE) begin
        o_crc_value <= lfsr;
        o_crc_valid <= 1'b1;
`ifdef CRC_CHECK_EN
        o_crc_error <= lfsr != rx_q;
`endif
      end
    end
endmodule

// File: doc/crc_lfsr_engine.md
Name: crc_lfsr_engine

Overview:
Parametrised bit-serial CRC generator for HDR-DDR framing. It replaces the fixed 8-bit/CRC5 calculator with a generic engine that has configurable width, polynomial, seed, data width and bit order. Sits beside the TX/RX serialisers, accepts parallel beats under a valid/ready handshake, and reports the CRC once per frame on the beat flagged last. Default configuration is I3C HDR-DDR CRC5: G(x)=x^5+x^2+1, seed all-ones.

Parameters:
CRC_W, 5, CRC register width (2..16)
POLY, 5'b00101, polynomial taps excluding the implicit x^CRC_W term, CRC_W bits
SEED, 5'b11111, LFSR value loaded at start of every frame, CRC_W bits
DATA_W, 8, bits per input beat (1..32)
MSB_FIRST, 1, 1 = i_data[DATA_W-1] processed first; 0 = i_data[0] first

Ports:
i_sys_clk  in  1  clock; all logic on rising edge
i_sys_rst  in  1  asynchronous, active-low reset
i_enable  in  1  block enable; low = synchronous abort/clear
i_data  in  DATA_W  parallel data beat
i_valid  in  1  beat valid
i_last  in  1  beat is final beat of frame; qualified by i_valid & o_ready
o_ready  out  1  engine can accept a beat this cycle
o_crc_value  out  CRC_W  final CRC of last completed frame
o_crc_valid  out  1  one-cycle pulse, o_crc_value updated
o_busy  out  1  frame in progress (SHIFT or GAP)

Behaviour:
- Reset: o_ready=0, o_crc_value=0, o_crc_valid=0, o_busy=0, LFSR=SEED, bit counter=0, state IDLE. Asynchronous reset mid-frame discards the frame.
- States:
  - IDLE: o_ready=i_enable. On accept (i_valid & o_ready), load the LFSR with SEED, latch i_data and i_last, then go to SHIFT.
  - SHIFT: o_ready=0. Process one bit per cycle for DATA_W cycles; the counter runs 0..DATA_W-1. At count DATA_W-1: go to DONE if the latched last flag is set, else go to GAP.
  - GAP: o_ready=1 and the LFSR is held. On accept, latch the beat (no reseed) and go to SHIFT. A gap may last any number of cycles.
  - DONE: o_crc_value<=LFSR and o_crc_valid=1 for exactly this cycle, then IDLE. o_ready=0 in DONE.
- Per-bit update: fb = bit ^ LFSR[CRC_W-1]; LFSR <= {LFSR[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). No output reflection and no final XOR.
- Latency: a beat accepted on edge T has its bits processed on edges T+1..T+DATA_W. For a last beat, o_crc_valid is high in the cycle after edge T+DATA_W+1, so the pulse is visible DATA_W+1 cycles after acceptance. Minimum beat spacing is DATA_W+1 cycles.
- o_crc_value holds its value until the next DONE; it does not clear on a new frame start.
- o_busy=1 in SHIFT and GAP.
- i_valid while o_ready=0 is ignored; the upstream block must hold the beat. i_data and i_last are don't-care unless accepted.
- i_enable low in any state: next edge goes to IDLE, LFSR<=SEED, counter<=0, o_crc_valid<=0, o_crc_value<=0. Any partial frame is lost. No output while disabled.
- i_enable rising: first accept possible in the same cycle, since o_ready follows i_enable in IDLE.
- Single-beat frame: accept in IDLE with i_last=1 goes IDLE→SHIFT→DONE.

Optional Feature:
Macro CRC_CHECK_EN.
- When defined: adds input i_rx_crc [CRC_W-1:0], sampled with the last beat on accept, and output o_crc_error (reset 0).
  - In DONE, o_crc_error = (LFSR != latched i_rx_crc), valid in the same cycle as o_crc_valid.
  - o_crc_error holds until the next DONE, or until i_enable goes low, which clears it.
- When undefined: neither port exists and there is no compare logic. Generator-only behaviour is otherwise identical.

Test Plan:
1. Default params, single beat 0x00 with i_last=1 → o_crc_valid pulse 9 cycles after accept, o_crc_value=5'h0F.
2. Two beats 0x00, 0x00 (last on the second), 3-cycle gap between them → one o_crc_valid pulse only, o_crc_value=5'h01; o_ready=0 during SHIFT and 1 during GAP.
3. Instance with SEED=0, single beat 0x80 → 5'h0E. Same instance with beat 0x00 → 5'h00.
4. Drop i_enable for 1 cycle mid-SHIFT of beat 1, then send a fresh single beat 0x00 → no pulse for the aborted frame; next result is 5'h0F. o_crc_value=0 after the abort.
5. Assert i_sys_rst low mid-frame, release it, resend frame 1 → all outputs 0 during reset; result 5'h0F. Hold i_valid during SHIFT → no extra beat consumed.
6. CRC_CHECK_EN defined, beat 0x00 with i_rx_crc=5'h0F → o_crc_error=0. Repeat with i_rx_crc=5'h0E → o_crc_error=1, coincident with o_crc_valid.
